// File: rtl/threshold.sv
// Binary activation stage: maps a signed sum to 0/ACTV and, when training,
// returns the error gated by whether the latched sum lies inside the window.
module threshold #(
  parameter int              ARGW = 16,
  parameter int              RESW = 16,
  parameter int              ERRW = 16,
  parameter logic [RESW-1:0] ACTV = 16'h00ff,
  parameter logic [ARGW-1:0] WIN  = 16'h0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            arg_valid,
  input  logic [ARGW-1:0] arg_data,
  output logic            arg_ready,
  output logic            res_valid,
  output logic [RESW-1:0] res_data,
  input  logic            res_ready,
  input  logic            err_valid,
  input  logic [ERRW-1:0] err_data,
  output logic            err_ready,
  output logic            fbk_valid,
  output logic [ERRW-1:0] fbk_data,
  input  logic            fbk_ready
);

  // Handshake: a word moves on the rising edge where valid && ready; a raised
  // valid holds its data until taken, and every ready/valid here is a pure
  // decode of the registered state, so no input reaches an output combinationally.

  localparam logic [1:0] S_ARG = 2'd0;
  localparam logic [1:0] S_RES = 2'd1;
  localparam logic [1:0] S_ERR = 2'd2;
  localparam logic [1:0] S_FBK = 2'd3;

  logic [1:0]      state;
  logic [ARGW-1:0] x;
  logic            trn;

  logic arg_fire;
  logic res_fire;
  logic err_fire;
  logic fbk_fire;

  assign arg_ready = (state == S_ARG);
  assign res_valid = (state == S_RES);
  assign err_ready = (state == S_ERR);
  assign fbk_valid = (state == S_FBK);

  assign arg_fire = arg_valid && arg_ready;
  assign res_fire = res_valid && res_ready;
  assign err_fire = err_valid && err_ready;
  assign fbk_fire = fbk_valid && fbk_ready;

  // Magnitude is taken one bit wider so the most negative sum stays large.
  logic [ARGW:0] x_ext;
  logic [ARGW:0] x_abs;
  logic          in_win;

  assign x_ext  = {x[ARGW-1], x};
  assign x_abs  = x_ext[ARGW] ? ((~x_ext) + {{ARGW{1'b0}}, 1'b1}) : x_ext;
  assign in_win = (x_abs < {1'b0, WIN});

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_ARG;
      x        <= '0;
      trn      <= 1'b0;
      res_data <= '0;
      fbk_data <= '0;
    end else begin
      case (state)
        S_ARG: begin
          if (arg_fire) begin
            x        <= arg_data;
            trn      <= en;
            res_data <= arg_data[ARGW-1] ? '0 : ACTV;
            state    <= S_RES;
          end
        end
        S_RES: begin
          if (res_fire) begin
            state <= trn ? S_ERR : S_ARG;
          end
        end
        S_ERR: begin
          if (err_fire) begin
            fbk_data <= in_win ? err_data : '0;
            state    <= S_FBK;
          end
        end
        S_FBK: begin
          if (fbk_fire) begin
            state <= S_ARG;
          end
        end
        default: state <= S_ARG;
      endcase
    end
  end

endmodule
